bomb_scheduler: RTL and testbench
=================================

BOMB_SCHEDULER -- requirements
Module: bomb_scheduler

Interface
REQ-001 Parameter TICK_DIV, default 25_000_000, cycles per bomb phase (1 s at 25 MHz); SHALL be >= 8.
REQ-002 pixel_clk  in  1  sole clock, rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 p1_req  in  1  one-cycle pulse: player 1 places a bomb at (p1_x, p1_y).
REQ-005 p1_x, p1_y  in  4 each  arena column/row; valid 0..9.
REQ-006 p1_ack, p1_nack  out  1 each  one-cycle accept/reject pulse for p1_req.
REQ-007 p2_req, p2_x, p2_y, p2_ack, p2_nack  same widths/meaning for player 2.
REQ-008 wr_en  out  1  one-cycle write strobe to the 10x10 Bomb grid.
REQ-009 wr_x, wr_y  out  4 each  cell addressed by wr_en.
REQ-010 wr_state  out  2  value written: 0 empty, 1 new bomb, 2 aged bomb, 3 exploding.
REQ-011 blast_valid  out  1  one-cycle pulse coincident with the wr_en carrying wr_state=3.
REQ-012 active_cnt  out  3  number of non-IDLE slots, 0..4.

Function
REQ-013 Four bomb slots SHALL exist; slots 0-1 belong to player 1, slots 2-3 to player 2.
REQ-014 Slot FSM SHALL be IDLE -> FUSE1 -> FUSE2 -> BLAST -> IDLE; each non-IDLE state lasts exactly TICK_DIV cycles, timed by the slot's own counter reset on state entry.
REQ-015 Each state entry (FUSE1, FUSE2, BLAST) and the BLAST->IDLE exit SHALL raise that slot's pending-write flag carrying state 1, 2, 3, or 0 respectively.
REQ-016 A request sampled in cycle N SHALL be accepted when: coordinate <= 9, the owning player has an IDLE slot, and no non-IDLE slot holds that cell; otherwise rejected.
REQ-017 On acceptance, the lowest-index IDLE slot of that player SHALL enter FUSE1 at the end of cycle N; ack (or nack) SHALL be high in cycle N+1 only.
REQ-018 Both players requesting the same free cell in the same cycle: the player holding round-robin priority wins, the other gets nack; priority SHALL flip after every such conflict; reset priority = player 1.
REQ-019 Requests for different cells in the same cycle SHALL both be evaluated independently and may both be accepted.
REQ-020 Write arbiter SHALL grant one pending slot per cycle, lowest index first, register wr_en/wr_x/wr_y/wr_state, and clear the granted flag.
REQ-021 Uncontended placement SHALL produce wr_en (state 1) in cycle N+2.
REQ-022 Worst-case pending-write latency SHALL be 4 cycles; no pending write may be lost or overwritten (guaranteed by REQ-001).
REQ-023 A slot returning to IDLE SHALL be reusable only after its state-0 write has been issued; its cell is considered occupied until then.
REQ-024 active_cnt SHALL update in the cycle after the corresponding state change.

Reset
REQ-025 On rst: all slots IDLE, counters and pending flags 0, priority = player 1; wr_en, blast_valid, ack/nack outputs 0; wr_x, wr_y, wr_state 0; active_cnt 0.
REQ-026 Reset mid-operation SHALL issue no clear writes; the Bomb grid owner clears its own storage on rst.
REQ-027 Requests sampled during rst SHALL be ignored (no ack, no nack).

Structure
REQ-028 Shared package bomb_pkg SHALL hold GRID_N=10, COORD_W=4, NSLOT=4, and the 2-bit bomb-state encoding (EMPTY, NEW, AGED, EXPLODE).
REQ-029 One sub-module bomb_slot (FSM, TICK_DIV counter, stored x/y, pending flag) SHALL be instantiated four times; arbitration and request checks stay in the top level.

Verification (TICK_DIV=16)
REQ-030 p1_req at (3,4) in cycle 0 -> p1_ack cycle 1; wr (3,4,1) cycle 2; wr (3,4,2) cycle 18; wr (3,4,3) + blast_valid cycle 34; wr (3,4,0) cycle 50; active_cnt 1 then 0.
REQ-031 p1 and p2 request (5,5) in cycle 0 -> p1_ack, p2_nack; repeat after clear -> p2_ack, p1_nack.
REQ-032 p1 places three bombs at distinct cells -> third gets p1_nack; active_cnt = 2.
REQ-033 p1 at (2,2) and p2 at (7,7) in the same cycle -> both acks; writes slot 0 cycle 2, slot 2 cycle 3; all later phase writes likewise one cycle apart.
REQ-034 p2_req with x=10, or at a cell already holding an active bomb -> p2_nack, no write.
REQ-035 rst asserted while two bombs are in FUSE2 -> next cycle all outputs 0, no state-0 writes, active_cnt 0; new request afterwards -> normal REQ-030 timing.

Source files
------------

// File: rtl/bomb_pkg.sv
// Shared constants and encodings for the bomb scheduler and its slots.
package bomb_pkg;
  localparam int GRID_N  = 10;
  localparam int COORD_W = 4;
  localparam int NSLOT   = 4;
  localparam int SLOT_W  = $clog2(NSLOT);
  localparam logic [COORD_W-1:0] COORD_MAX = COORD_W'(GRID_N - 1);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    NEW     = 2'd1,
    AGED    = 2'd2,
    EXPLODE = 2'd3
  } bomb_state_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FUSE1 = 2'd1,
    S_FUSE2 = 2'd2,
    S_BLAST = 2'd3
  } slot_state_e;
endpackage

// File: rtl/bomb_slot.sv
// One bomb: fuse/blast phase FSM, phase timer, stored cell and a pending-write flag.
module bomb_slot
  import bomb_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic               pixel_clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  input  logic               i_grant,
  output logic               o_active,
  output logic               o_free,
  output logic               o_pend,
  output bomb_state_e        o_state,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y
);
  localparam int CNT_W = $clog2(TICK_DIV);

  slot_state_e        r_state;
  slot_state_e        w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_pend;
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic               w_tick;
  logic               w_change;

  always_comb begin
    w_next = r_state;
    w_tick = (r_cnt == CNT_W'(TICK_DIV - 1));
    case (r_state)
      S_IDLE:  if (i_start && !r_pend) w_next = S_FUSE1;
      S_FUSE1: if (w_tick) w_next = S_FUSE2;
      S_FUSE2: if (w_tick) w_next = S_BLAST;
      S_BLAST: if (w_tick) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    w_change = (w_next != r_state);
  end

  // Every phase change (including the return to IDLE) owes the grid one write.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_change || r_state == S_IDLE) ? '0 : r_cnt + CNT_W'(1);
      if (w_change)     r_pend <= 1'b1;
      else if (i_grant) r_pend <= 1'b0;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (r_state == S_IDLE && !r_pend && i_start) begin
      r_x <= i_x;
      r_y <= i_y;
    end
  end

  // The pending value is simply the current phase: a write drains long before the next phase.
  always_comb begin
    case (r_state)
      S_FUSE1: o_state = NEW;
      S_FUSE2: o_state = AGED;
      S_BLAST: o_state = EXPLODE;
      default: o_state = EMPTY;
    endcase
  end

  assign o_active = (r_state != S_IDLE);
  assign o_free   = !o_active && !r_pend;
  assign o_pend   = r_pend;
  assign o_x      = r_x;
  assign o_y      = r_y;
endmodule

// File: rtl/bomb_scheduler.sv
// Four-slot bomb scheduler: request checking, same-cell round-robin and grid write arbiter.
module bomb_scheduler
  import bomb_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic               pixel_clk,
  input  logic               rst,
  input  logic               p1_req,
  input  logic [COORD_W-1:0] p1_x,
  input  logic [COORD_W-1:0] p1_y,
  output logic               p1_ack,
  output logic               p1_nack,
  input  logic               p2_req,
  input  logic [COORD_W-1:0] p2_x,
  input  logic [COORD_W-1:0] p2_y,
  output logic               p2_ack,
  output logic               p2_nack,
  output logic               wr_en,
  output logic [COORD_W-1:0] wr_x,
  output logic [COORD_W-1:0] wr_y,
  output logic [1:0]         wr_state,
  output logic               blast_valid,
  output logic [2:0]         active_cnt
);
  logic [NSLOT-1:0]   w_active, w_free, w_pend, w_start, w_grant;
  bomb_state_e        w_state [NSLOT];
  logic [COORD_W-1:0] w_sx [NSLOT];
  logic [COORD_W-1:0] w_sy [NSLOT];

  for (genvar g = 0; g < NSLOT; g++) begin : g_slot
    bomb_slot #(.TICK_DIV(TICK_DIV)) u_slot (
      .pixel_clk (pixel_clk),
      .rst       (rst),
      .i_start   (w_start[g]),
      .i_x       ((g < 2) ? p1_x : p2_x),
      .i_y       ((g < 2) ? p1_y : p2_y),
      .i_grant   (w_grant[g]),
      .o_active  (w_active[g]),
      .o_free    (w_free[g]),
      .o_pend    (w_pend[g]),
      .o_state   (w_state[g]),
      .o_x       (w_sx[g]),
      .o_y       (w_sy[g])
    );
  end

  logic w_p1_hit, w_p2_hit, w_p1_elig, w_p2_elig, w_conflict, w_p1_acc, w_p2_acc;
  logic r_prio_p2;

  // A cell stays occupied until its slot's clearing write has gone out.
  always_comb begin
    w_p1_hit = 1'b0;
    w_p2_hit = 1'b0;
    for (int i = 0; i < NSLOT; i++) begin
      if (!w_free[i] && w_sx[i] == p1_x && w_sy[i] == p1_y) w_p1_hit = 1'b1;
      if (!w_free[i] && w_sx[i] == p2_x && w_sy[i] == p2_y) w_p2_hit = 1'b1;
    end
    w_p1_elig  = p1_req && (p1_x <= COORD_MAX) && (p1_y <= COORD_MAX) && !w_p1_hit
                 && (w_free[0] || w_free[1]);
    w_p2_elig  = p2_req && (p2_x <= COORD_MAX) && (p2_y <= COORD_MAX) && !w_p2_hit
                 && (w_free[2] || w_free[3]);
    w_conflict = w_p1_elig && w_p2_elig && (p1_x == p2_x) && (p1_y == p2_y);
    w_p1_acc   = w_p1_elig && (!w_conflict || !r_prio_p2);
    w_p2_acc   = w_p2_elig && (!w_conflict ||  r_prio_p2);
    w_start    = '0;
    w_start[0] = w_p1_acc &&  w_free[0];
    w_start[1] = w_p1_acc && !w_free[0];
    w_start[2] = w_p2_acc &&  w_free[2];
    w_start[3] = w_p2_acc && !w_free[2];
  end

  logic              w_any;
  logic [SLOT_W-1:0] w_gidx;
  logic [2:0]        w_cnt;

  always_comb begin
    w_any  = |w_pend;
    w_gidx = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (w_pend[i]) w_gidx = SLOT_W'(i);
    end
    w_grant = '0;
    if (w_any) w_grant[w_gidx] = 1'b1;
    w_cnt = '0;
    for (int i = 0; i < NSLOT; i++) w_cnt = w_cnt + 3'(w_active[i]);
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      r_prio_p2   <= 1'b0;
      p1_ack      <= 1'b0;
      p1_nack     <= 1'b0;
      p2_ack      <= 1'b0;
      p2_nack     <= 1'b0;
      wr_en       <= 1'b0;
      wr_x        <= '0;
      wr_y        <= '0;
      wr_state    <= EMPTY;
      blast_valid <= 1'b0;
      active_cnt  <= '0;
    end else begin
      p1_ack      <= w_p1_acc;
      p1_nack     <= p1_req && !w_p1_acc;
      p2_ack      <= w_p2_acc;
      p2_nack     <= p2_req && !w_p2_acc;
      if (w_conflict) r_prio_p2 <= !r_prio_p2;
      wr_en       <= w_any;
      blast_valid <= w_any && (w_state[w_gidx] == EXPLODE);
      if (w_any) begin
        wr_x     <= w_sx[w_gidx];
        wr_y     <= w_sy[w_gidx];
        wr_state <= w_state[w_gidx];
      end
      active_cnt  <= w_cnt;
    end
  end
endmodule

// File: tb/tb_bomb_scheduler.sv
// Directed bench for bomb_scheduler with a 16-cycle bomb phase.
module tb_bomb_scheduler;
  localparam int TD = 16;

  logic       pixel_clk = 1'b0;
  logic       rst;
  logic       p1_req, p2_req;
  logic [3:0] p1_x, p1_y, p2_x, p2_y;
  logic       p1_ack, p1_nack, p2_ack, p2_nack;
  logic       wr_en, blast_valid;
  logic [3:0] wr_x, wr_y;
  logic [1:0] wr_state;
  logic [2:0] active_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bomb_scheduler #(.TICK_DIV(TD)) dut (
    .pixel_clk   (pixel_clk),
    .rst         (rst),
    .p1_req      (p1_req),
    .p1_x        (p1_x),
    .p1_y        (p1_y),
    .p1_ack      (p1_ack),
    .p1_nack     (p1_nack),
    .p2_req      (p2_req),
    .p2_x        (p2_x),
    .p2_y        (p2_y),
    .p2_ack      (p2_ack),
    .p2_nack     (p2_nack),
    .wr_en       (wr_en),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .wr_state    (wr_state),
    .blast_valid (blast_valid),
    .active_cnt  (active_cnt)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic step();
    @(posedge pixel_clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_wr(input string tag, input logic en, input logic [3:0] x, input logic [3:0] y,
                        input logic [1:0] st, input logic bl);
    chk(tag, 32'({wr_en, wr_x, wr_y, wr_state, blast_valid}), 32'({en, x, y, st, bl}));
  endtask

  task automatic chk_ack(input string tag, input logic [3:0] e);
    chk(tag, 32'({p1_ack, p1_nack, p2_ack, p2_nack}), 32'(e));
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, 32'({wr_en, wr_x, wr_y, wr_state, blast_valid, p1_ack, p1_nack, p2_ack, p2_nack,
                  active_cnt}), 32'd0);
  endtask

  task automatic set_p1(input logic r, input logic [3:0] x, input logic [3:0] y);
    p1_req = r; p1_x = x; p1_y = y;
  endtask

  task automatic set_p2(input logic r, input logic [3:0] x, input logic [3:0] y);
    p2_req = r; p2_x = x; p2_y = y;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    set_p1(0, 0, 0);
    set_p2(0, 0, 0);
    step();
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    set_p1(0, 0, 0);
    set_p2(0, 0, 0);
    repeat (3) step();
    chk_all_zero("reset_outputs");
    rst = 1'b0;

    // Single bomb lifecycle
    cyc = 0;
    set_p1(1, 3, 4);
    step();
    set_p1(0, 0, 0);
    chk_ack("A_ack", 4'b1000);
    chk("A_no_wr_c1", 32'(wr_en), 32'd0);
    step();
    chk_wr("A_new", 1, 3, 4, 1, 0);
    chk("A_cnt1", 32'(active_cnt), 32'd1);
    chk_ack("A_ack_one_cycle", 4'b0000);
    step();
    chk("A_no_wr_c3", 32'(wr_en), 32'd0);
    run_to(17);
    chk("A_no_wr_c17", 32'(wr_en), 32'd0);
    run_to(18);
    chk_wr("A_aged", 1, 3, 4, 2, 0);
    run_to(34);
    chk_wr("A_explode", 1, 3, 4, 3, 1);
    run_to(35);
    chk("A_blast_one_cycle", 32'({wr_en, blast_valid}), 32'd0);
    run_to(48);
    chk("A_cnt_still1", 32'(active_cnt), 32'd1);
    run_to(50);
    chk_wr("A_clear", 1, 3, 4, 0, 0);
    chk("A_cnt0", 32'(active_cnt), 32'd0);

    // Same-cell conflict, priority flips
    cyc = 0;
    set_p1(1, 5, 5);
    set_p2(1, 5, 5);
    step();
    set_p1(0, 0, 0);
    set_p2(0, 0, 0);
    chk_ack("B_conf1", 4'b1001);
    step();
    chk_wr("B_wr1", 1, 5, 5, 1, 0);
    run_to(50);
    chk_wr("B_clear1", 1, 5, 5, 0, 0);
    cyc = 0;
    set_p1(1, 5, 5);
    set_p2(1, 5, 5);
    step();
    set_p2(0, 0, 0);
    chk_ack("B_conf2", 4'b0110);
    step();
    chk_wr("B_wr2", 1, 5, 5, 1, 0);
    step();
    set_p1(0, 0, 0);
    chk_ack("B_p1_occupied", 4'b0100);

    // Slot exhaustion and rejected requests
    reset_pulse();
    set_p1(1, 1, 1);
    step();
    chk_ack("C_ack1", 4'b1000);
    set_p1(1, 2, 1);
    step();
    chk_ack("C_ack2", 4'b1000);
    chk_wr("C_wr1", 1, 1, 1, 1, 0);
    set_p1(1, 3, 1);
    step();
    set_p1(0, 0, 0);
    chk_ack("C_third_nack", 4'b0100);
    chk_wr("C_wr2", 1, 2, 1, 1, 0);
    set_p2(1, 1, 1);
    step();
    chk("C_cnt2", 32'(active_cnt), 32'd2);
    chk("C_no_wr_third", 32'(wr_en), 32'd0);
    chk_ack("C_p2_occupied", 4'b0001);
    set_p2(1, 10, 3);
    step();
    set_p2(0, 0, 0);
    chk_ack("C_p2_x10", 4'b0001);
    chk("C_no_wr_c5", 32'(wr_en), 32'd0);
    step();
    chk("C_no_wr_c6", 32'(wr_en), 32'd0);

    // Independent placements, writes one cycle apart
    reset_pulse();
    set_p1(1, 2, 2);
    set_p2(1, 7, 7);
    step();
    set_p1(0, 0, 0);
    set_p2(0, 0, 0);
    chk_ack("D_both_ack", 4'b1010);
    step();
    chk_wr("D_new_s0", 1, 2, 2, 1, 0);
    step();
    chk_wr("D_new_s2", 1, 7, 7, 1, 0);
    run_to(18);
    chk_wr("D_aged_s0", 1, 2, 2, 2, 0);
    run_to(19);
    chk_wr("D_aged_s2", 1, 7, 7, 2, 0);
    run_to(34);
    chk_wr("D_expl_s0", 1, 2, 2, 3, 1);
    run_to(35);
    chk_wr("D_expl_s2", 1, 7, 7, 3, 1);
    run_to(50);
    chk_wr("D_clear_s0", 1, 2, 2, 0, 0);
    run_to(51);
    chk_wr("D_clear_s2", 1, 7, 7, 0, 0);

    // Reset while two bombs are in FUSE2
    reset_pulse();
    set_p1(1, 1, 2);
    set_p2(1, 3, 4);
    step();
    set_p1(0, 0, 0);
    set_p2(0, 0, 0);
    run_to(20);
    chk("E_cnt2", 32'(active_cnt), 32'd2);
    rst = 1'b1;
    set_p1(1, 0, 0);
    step();
    rst = 1'b0;
    set_p1(0, 0, 0);
    chk_all_zero("E_after_rst");
    for (int k = 0; k < 5; k++) begin
      step();
      chk("E_no_clear_wr", 32'({wr_en, p1_ack, p1_nack, active_cnt}), 32'd0);
    end
    cyc = 0;
    set_p1(1, 6, 6);
    step();
    set_p1(0, 0, 0);
    chk_ack("E_ack", 4'b1000);
    step();
    chk_wr("E_new", 1, 6, 6, 1, 0);
    chk("E_cnt1", 32'(active_cnt), 32'd1);
    run_to(18);
    chk_wr("E_aged", 1, 6, 6, 2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
